// File: rtl/debug_pkg.sv
// Shared constants, parser state encoding and hex decoding for the debug command link.
package debug_pkg;

  localparam logic [7:0] CH_H  = 8'h48;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_B  = 8'h42;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_HEX  = 2'd1,
    P_TERM = 2'd2,
    P_ERR  = 2'd3
  } parse_state_t;

  // Returns {valid, nibble}; valid is low for anything outside 0-9, A-F, a-f.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] ch);
    logic [4:0] r;
    r = 5'b0_0000;
    if (ch >= 8'h30 && ch <= 8'h39)      r = {1'b1, 4'(ch - 8'h30)};
    else if (ch >= 8'h41 && ch <= 8'h46) r = {1'b1, 4'(ch - 8'h37)};
    else if (ch >= 8'h61 && ch <= 8'h66) r = {1'b1, 4'(ch - 8'h57)};
    return r;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx, mid-bit sampling, glitch rejection on the start bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  rx_state_t      state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2:0]     bit_reg;
  logic           rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      state_reg   <= R_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      cnt_reg     <= cnt_reg + 1'b1;
      case (state_reg)
        R_IDLE: begin
          cnt_reg <= '0;
          if (rx_prev_reg && !rx_sync_reg) state_reg <= R_START;
        end
        R_START: if (cnt_reg == CW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_reg   <= '0;
          bit_reg   <= '0;
          state_reg <= rx_sync_reg ? R_IDLE : R_DATA;
        end
        R_DATA: if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
          cnt_reg   <= '0;
          byte_data <= {rx_sync_reg, byte_data[7:1]};
          bit_reg   <= bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_reg <= R_STOP;
        end
        R_STOP: if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
          if (rx_sync_reg) begin
            byte_valid <= 1'b1;
            state_reg  <= R_IDLE;
          end else begin
            frame_err  <= 1'b1;
            state_reg  <= R_WAIT;
          end
        end
        default: if (rx_sync_reg) state_reg <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_cmd_rx.sv
// Parses host ASCII command lines into halt/step/breakpoint controls for the CPU core.
module debug_cmd_rx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_DIGITS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic [15:0]              pc,
  output logic                     halt,
  output logic                     step,
  output logic [4*ADDR_DIGITS-1:0] bp_addr,
  output logic                     bp_enable,
  output logic                     cmd_ok,
  output logic                     cmd_error
);

  localparam int ADDR_W = 4 * ADDR_DIGITS;
  localparam int DW     = $clog2(ADDR_DIGITS + 1);

  logic [7:0]        byte_data;
  logic              byte_valid, frame_err;
  parse_state_t      state_reg;
  logic [7:0]        cmd_reg;
  logic [ADDR_W-1:0] shadow_reg;
  logic [DW-1:0]     digit_cnt_reg;
  logic [15:0]       prev_pc_reg;
  logic              is_term, bp_hit;
  logic [4:0]        hex_nib;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign is_term = (byte_data == CH_CR) || (byte_data == CH_LF);
  assign hex_nib = hex_to_nibble(byte_data);
  // Edge-qualified so resuming from the breakpoint address does not immediately re-halt.
  assign bp_hit  = bp_enable && !halt && (pc == 16'(bp_addr)) && (pc != prev_pc_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= P_IDLE;
      cmd_reg       <= '0;
      shadow_reg    <= '0;
      digit_cnt_reg <= '0;
      prev_pc_reg   <= '0;
      halt          <= 1'b0;
      step          <= 1'b0;
      bp_addr       <= '0;
      bp_enable     <= 1'b0;
      cmd_ok        <= 1'b0;
      cmd_error     <= 1'b0;
    end else begin
      prev_pc_reg <= pc;
      step        <= 1'b0;
      cmd_ok      <= 1'b0;
      cmd_error   <= 1'b0;
      if (frame_err) begin
        state_reg <= P_ERR;
      end else if (byte_valid) begin
        case (state_reg)
          P_IDLE: if (!is_term) begin
            cmd_reg <= byte_data;
            if (byte_data inside {CH_H, CH_C, CH_S, CH_X}) begin
              state_reg <= P_TERM;
            end else if (byte_data == CH_B) begin
              state_reg     <= P_HEX;
              digit_cnt_reg <= '0;
            end else begin
              state_reg <= P_ERR;
            end
          end
          P_HEX: begin
            if (hex_nib[4]) begin
              shadow_reg    <= (shadow_reg << 4) | ADDR_W'(hex_nib[3:0]);
              digit_cnt_reg <= digit_cnt_reg + 1'b1;
              if (digit_cnt_reg == DW'(ADDR_DIGITS - 1)) state_reg <= P_TERM;
            end else if (is_term) begin
              cmd_error <= 1'b1;
              state_reg <= P_IDLE;
            end else begin
              state_reg <= P_ERR;
            end
          end
          P_TERM: begin
            if (is_term) begin
              cmd_ok    <= 1'b1;
              state_reg <= P_IDLE;
              case (cmd_reg)
                CH_H: halt <= 1'b1;
                CH_C: halt <= 1'b0;
                CH_S: step <= halt;
                CH_B: begin
                  bp_addr   <= shadow_reg;
                  bp_enable <= 1'b1;
                end
                default: bp_enable <= 1'b0;
              endcase
            end else begin
              state_reg <= P_ERR;
            end
          end
          default: if (is_term) begin
            cmd_error <= 1'b1;
            state_reg <= P_IDLE;
          end
        endcase
      end
      // Placed last so a hit overrides a concurrent continue.
      if (bp_hit) halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_cmd_rx.sv
// Directed bench for debug_cmd_rx: UART-framed command lines with hand-computed expectations.
module tb_debug_cmd_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        halt, step, bp_enable, cmd_ok, cmd_error;
  logic [15:0] bp_addr;

  int checks = 0;
  int errors = 0;

  int cyc = 0, bv_cyc = 0, ok_cyc = 0, err_cyc = 0;
  int ok_cnt = 0, err_cnt = 0, step_cnt = 0, bv_cnt = 0;
  int ok0, err0, step0, bv0;

  debug_cmd_rx #(.CLKS_PER_BIT(CPB), .ADDR_DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .pc        (pc),
    .halt      (halt),
    .step      (step),
    .bp_addr   (bp_addr),
    .bp_enable (bp_enable),
    .cmd_ok    (cmd_ok),
    .cmd_error (cmd_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.u_rx.byte_valid) begin bv_cyc <= cyc; bv_cnt <= bv_cnt + 1; end
    if (cmd_ok)    begin ok_cyc <= cyc;  ok_cnt <= ok_cnt + 1;   end
    if (cmd_error) begin err_cyc <= cyc; err_cnt <= err_cnt + 1; end
    if (step) step_cnt <= step_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    ok0 = ok_cnt; err0 = err_cnt; step0 = step_cnt; bv0 = bv_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_halt", halt, 0);
    chk("rst_step", step, 0);
    chk("rst_bp_addr", bp_addr, 16'h0000);
    chk("rst_bp_en", bp_enable, 0);
    chk("rst_ok", cmd_ok, 0);
    chk("rst_err", cmd_error, 0);

    snap();
    send_str("H");
    chk("H_no_ok_yet", ok_cnt - ok0, 0);
    chk("H_no_halt_yet", halt, 0);
    send_str("\n");
    chk("H_halt", halt, 1);
    chk("H_ok_count", ok_cnt - ok0, 1);
    chk("H_ok_latency", ok_cyc - bv_cyc, 1);

    snap();
    send_str("C\r\n");
    chk("C_halt", halt, 0);
    chk("C_ok_count", ok_cnt - ok0, 1);
    chk("C_no_err", err_cnt - err0, 0);

    snap();
    send_str("B01aF\n");
    chk("B_addr", bp_addr, 16'h01AF);
    chk("B_en", bp_enable, 1);
    chk("B_ok_count", ok_cnt - ok0, 1);

    pc = 16'h01AE;
    @(negedge clk);
    chk("bp_pre_halt", halt, 0);
    pc = 16'h01AF;
    @(negedge clk);
    chk("bp_hit_halt", halt, 1);

    send_str("C\n");
    chk("bp_continue_no_rehalt", halt, 0);
    pc = 16'h01B0;
    @(negedge clk);
    chk("bp_away_halt", halt, 0);
    pc = 16'h01AF;
    @(negedge clk);
    chk("bp_reenter_halt", halt, 1);

    snap();
    send_str("S\n");
    chk("S_step_cycles", step_cnt - step0, 1);
    chk("S_halt_kept", halt, 1);
    chk("S_ok", ok_cnt - ok0, 1);

    send_str("C\n");
    chk("C2_halt", halt, 0);
    snap();
    send_str("S\n");
    chk("S_run_no_step", step_cnt - step0, 0);
    chk("S_run_ok", ok_cnt - ok0, 1);
    chk("S_run_halt", halt, 0);

    snap();
    send_str("B12G4\n");
    chk("E1_err", err_cnt - err0, 1);
    chk("E1_err_on_term", err_cyc - bv_cyc, 1);
    send_str("B12\n");
    chk("E2_err", err_cnt - err0, 2);
    chk("E2_err_on_term", err_cyc - bv_cyc, 1);
    send_str("B12345\n");
    chk("E3_err", err_cnt - err0, 3);
    chk("E3_err_on_term", err_cyc - bv_cyc, 1);
    send_str("Q\n");
    chk("E4_err", err_cnt - err0, 4);
    chk("E4_err_on_term", err_cyc - bv_cyc, 1);
    chk("E_no_ok", ok_cnt - ok0, 0);
    chk("E_addr_kept", bp_addr, 16'h01AF);
    chk("E_en_kept", bp_enable, 1);

    snap();
    send_byte(8'h48, 1'b0);
    send_str("\n");
    chk("FE_err", err_cnt - err0, 1);
    chk("FE_no_ok", ok_cnt - ok0, 0);
    chk("FE_halt", halt, 0);

    snap();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("glitch_no_byte", bv_cnt - bv0, 0);
    chk("glitch_no_err", err_cnt - err0, 0);

    send_str("B12");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_bp_en", bp_enable, 0);
    chk("mid_rst_bp_addr", bp_addr, 16'h0000);
    chk("mid_rst_halt", halt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    send_str("X\n");
    chk("X_ok", ok_cnt - ok0, 1);
    chk("X_no_err", err_cnt - err0, 0);
    chk("X_no_step", step_cnt - step0, 0);
    chk("X_halt", halt, 0);
    chk("X_bp_en", bp_enable, 0);
    chk("X_bp_addr", bp_addr, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
